// File: rtl/sprite_pkg.sv
// Shared defaults and FSM state type for the sprite frame writer.
package sprite_pkg;

   localparam int          DEF_OBJECT_WIDTH_X       = 32;
   localparam int          DEF_OBJECT_HEIGHT_Y      = 32;
   localparam logic [7:0]  DEF_TRANSPARENT_ENCODING = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CLEAR = 2'd2
   } state_t;

endpackage

// File: rtl/sprite_ram.sv
// Sprite pixel storage: one synchronous write port and one registered read-first read port.
module sprite_ram
   import sprite_pkg::*;
#(
   parameter int         DEPTH   = DEF_OBJECT_WIDTH_X * DEF_OBJECT_HEIGHT_Y,
   parameter int         ADDR_W  = $clog2(DEPTH),
   parameter logic [7:0] MISS_VAL = DEF_TRANSPARENT_ENCODING
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [7:0]        i_wr_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [7:0]        o_rd_data
);

   logic [7:0] r_mem [DEPTH];
   logic [7:0] r_rd_data;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Reading in a separate process returns the pre-write word on a same-address collision.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rd_data <= MISS_VAL;
      end else if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end else begin
         r_rd_data <= MISS_VAL;
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sprite_frame_writer.sv
// Streams a raster-order sprite frame into a buffer and serves 1-cycle-latency pixel reads.
// Optional SPRITE_FRAME_WRITER_CLEAR_EN adds clear_req and a CLEAR sweep to transparent.
module sprite_frame_writer
   import sprite_pkg::*;
#(
   parameter int         OBJECT_WIDTH_X       = DEF_OBJECT_WIDTH_X,
   parameter int         OBJECT_HEIGHT_Y      = DEF_OBJECT_HEIGHT_Y,
   parameter logic [7:0] TRANSPARENT_ENCODING = DEF_TRANSPARENT_ENCODING
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_start,
   input  logic        wr_valid,
   input  logic [7:0]  wr_data,
   output logic        wr_ready,
   output logic        frame_done,
   output logic        busy,
   input  logic [10:0] offsetX,
   input  logic [10:0] offsetY,
   input  logic        InsideRectangle,
   output logic [7:0]  RGBout,
   output logic        drawingRequest
`ifdef SPRITE_FRAME_WRITER_CLEAR_EN
   ,
   input  logic        clear_req
`endif
);

   localparam int DEPTH  = OBJECT_WIDTH_X * OBJECT_HEIGHT_Y;
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int COL_W  = (OBJECT_WIDTH_X > 1) ? $clog2(OBJECT_WIDTH_X) : 1;
   localparam int ROW_W  = (OBJECT_HEIGHT_Y > 1) ? $clog2(OBJECT_HEIGHT_Y) : 1;

   state_t             r_state, w_next_state;
   logic [COL_W-1:0]   r_col, w_next_col;
   logic [ROW_W-1:0]   r_row, w_next_row;
   logic               r_frame_done, w_done;
   logic               w_col_wrap, w_last, w_accept;
   logic               w_wr_en, w_rd_hit;
   logic [7:0]         w_wr_data;
   logic [ADDR_W-1:0]  w_wr_addr, w_rd_addr;

   assign w_col_wrap = (r_col == COL_W'(OBJECT_WIDTH_X - 1));
   assign w_last     = w_col_wrap && (r_row == ROW_W'(OBJECT_HEIGHT_Y - 1));
   assign wr_ready   = (r_state == LOAD) && !wr_start;
   assign w_accept   = wr_ready && wr_valid;
   assign busy       = (r_state != IDLE);
   assign frame_done = r_frame_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_col        <= '0;
         r_row        <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_col        <= w_next_col;
         r_row        <= w_next_row;
         r_frame_done <= w_done;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_col   = r_col;
      w_next_row   = r_row;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
`ifdef SPRITE_FRAME_WRITER_CLEAR_EN
            if (clear_req) begin
               w_next_state = CLEAR;
               w_next_col   = '0;
               w_next_row   = '0;
            end else if (wr_start) begin
`else
            if (wr_start) begin
`endif
               w_next_state = LOAD;
               w_next_col   = '0;
               w_next_row   = '0;
            end
         end
         LOAD: begin
            if (wr_start) begin
               w_next_col = '0;
               w_next_row = '0;
            end else if (wr_valid) begin
               if (w_last) begin
                  w_next_state = IDLE;
                  w_next_col   = '0;
                  w_next_row   = '0;
                  w_done       = 1'b1;
               end else if (w_col_wrap) begin
                  w_next_col = '0;
                  w_next_row = r_row + 1'b1;
               end else begin
                  w_next_col = r_col + 1'b1;
               end
            end
         end
`ifdef SPRITE_FRAME_WRITER_CLEAR_EN
         // The clear sweep reuses the raster counters, one address per cycle.
         CLEAR: begin
            if (w_last) begin
               w_next_state = IDLE;
               w_next_col   = '0;
               w_next_row   = '0;
            end else if (w_col_wrap) begin
               w_next_col = '0;
               w_next_row = r_row + 1'b1;
            end else begin
               w_next_col = r_col + 1'b1;
            end
         end
`endif
         default: begin
            w_next_state = IDLE;
            w_next_col   = '0;
            w_next_row   = '0;
         end
      endcase
   end

   assign w_wr_addr = ADDR_W'(32'(r_row) * 32'(OBJECT_WIDTH_X) + 32'(r_col));
`ifdef SPRITE_FRAME_WRITER_CLEAR_EN
   assign w_wr_en   = w_accept || (r_state == CLEAR);
   assign w_wr_data = (r_state == CLEAR) ? TRANSPARENT_ENCODING : wr_data;
`else
   assign w_wr_en   = w_accept;
   assign w_wr_data = wr_data;
`endif

   assign w_rd_hit  = InsideRectangle
                   && (offsetX < 11'(OBJECT_WIDTH_X))
                   && (offsetY < 11'(OBJECT_HEIGHT_Y));
   assign w_rd_addr = ADDR_W'(32'(offsetY) * 32'(OBJECT_WIDTH_X) + 32'(offsetX));

   sprite_ram #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .MISS_VAL (TRANSPARENT_ENCODING)
   ) u_ram (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (w_wr_addr),
      .i_wr_data (w_wr_data),
      .i_rd_en   (w_rd_hit),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (RGBout)
   );

   assign drawingRequest = (RGBout != TRANSPARENT_ENCODING);

endmodule

// File: tb/tb_sprite_frame_writer.sv
// Randomized self-checking bench for sprite_frame_writer against a beat-indexed frame model.
module tb_sprite_frame_writer;

   logic        clk = 1'b0;
   logic        reset, wr_start, wr_valid;
   logic [7:0]  wr_data;
   logic        wr_ready, frame_done, busy;
   logic [10:0] offsetX, offsetY;
   logic        InsideRectangle;
   logic [7:0]  RGBout;
   logic        drawingRequest;
`ifdef SPRITE_FRAME_WRITER_CLEAR_EN
   logic        clear_req;
`endif

   always #5 clk = ~clk;

   sprite_frame_writer dut (
      .clk             (clk),
      .reset           (reset),
      .wr_start        (wr_start),
      .wr_valid        (wr_valid),
      .wr_data         (wr_data),
      .wr_ready        (wr_ready),
      .frame_done      (frame_done),
      .busy            (busy),
      .offsetX         (offsetX),
      .offsetY         (offsetY),
      .InsideRectangle (InsideRectangle),
      .RGBout          (RGBout),
      .drawingRequest  (drawingRequest)
`ifdef SPRITE_FRAME_WRITER_CLEAR_EN
      ,
      .clear_req       (clear_req)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Frame model: pixels addressed by raster beat index y*32+x.
   logic [7:0] m_mem   [1024];
   bit         m_known [1024];
   bit         m_load, m_clr, m_done;
   int         m_idx, m_clr_cnt;
   int         err_ready, err_busy, err_done, err_rd, err_dr;
   int         done_pulses;

   task automatic tick();
      int         a;
      logic [7:0] exp_rd;
      bit         kn;
      #1;
      if (!reset && (wr_ready !== (m_load && !wr_start))) err_ready++;
      if (reset) begin
         exp_rd = 8'hFF; kn = 1'b1;
      end else if (InsideRectangle && offsetX < 32 && offsetY < 32) begin
         a = int'(offsetY) * 32 + int'(offsetX);
         exp_rd = m_mem[a]; kn = m_known[a];
      end else begin
         exp_rd = 8'hFF; kn = 1'b1;
      end
      m_done = 1'b0;
      if (reset) begin
         m_load = 1'b0; m_clr = 1'b0; m_idx = 0;
      end else if (m_load) begin
         if (wr_start) begin
            m_idx = 0;
         end else if (wr_valid) begin
            m_mem[m_idx] = wr_data; m_known[m_idx] = 1'b1;
            if (m_idx == 1023) begin
               m_load = 1'b0; m_idx = 0; m_done = 1'b1;
            end else begin
               m_idx++;
            end
         end
      end else if (m_clr) begin
         m_mem[1024 - m_clr_cnt] = 8'hFF; m_known[1024 - m_clr_cnt] = 1'b1;
         m_clr_cnt--;
         if (m_clr_cnt == 0) m_clr = 1'b0;
      end else begin
`ifdef SPRITE_FRAME_WRITER_CLEAR_EN
         if (clear_req) begin
            m_clr = 1'b1; m_clr_cnt = 1024;
         end else if (wr_start) begin
            m_load = 1'b1; m_idx = 0;
         end
`else
         if (wr_start) begin
            m_load = 1'b1; m_idx = 0;
         end
`endif
      end
      @(posedge clk);
      #1;
      if (busy !== (m_load || m_clr)) err_busy++;
      if (frame_done !== m_done) err_done++;
      if (frame_done === 1'b1) done_pulses++;
      if (kn && (RGBout !== exp_rd)) err_rd++;
      if (drawingRequest !== (RGBout != 8'hFF)) err_dr++;
   endtask

   task automatic test_reset();
      reset = 1'b1; wr_start = 1'b1; wr_valid = 1'b1; InsideRectangle = 1'b1;
      tick(); tick();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
      n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready got %0b want 0", wr_ready); end
      n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %0b want 0", frame_done); end
      n_tests++; if (RGBout !== 8'hFF) begin n_fail++; $display("FAIL reset_rgbout got %h want ff", RGBout); end
      n_tests++; if (drawingRequest !== 1'b0) begin n_fail++; $display("FAIL reset_drawreq got %0b want 0", drawingRequest); end
      reset = 1'b0; wr_start = 1'b0; wr_valid = 1'b0; InsideRectangle = 1'b0;
      tick();
   endtask

   task automatic test_load();
      wr_start = 1'b1; tick(); wr_start = 1'b0;
      wr_valid = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         wr_data = 8'(i);
         tick();
      end
      wr_valid = 1'b0;
      n_tests++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL load_frame_done got %0b want 1", frame_done); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL load_busy_after got %0b want 0", busy); end
      offsetX = 11'd5; offsetY = 11'd3; InsideRectangle = 1'b1;
      tick();
      n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL load_done_single got %0b want 0", frame_done); end
      n_tests++; if (RGBout !== 8'h65) begin n_fail++; $display("FAIL load_read_5_3 got %h want 65", RGBout); end
      n_tests++; if (drawingRequest !== 1'b1) begin n_fail++; $display("FAIL load_drawreq got %0b want 1", drawingRequest); end
   endtask

   task automatic send_beats(input int n, input logic [7:0] first);
      int acc = 0;
      while (acc < n) begin
         if ($urandom_range(0, 3) == 0) begin
            wr_valid = 1'b0; tick();
         end else begin
            wr_valid = 1'b1;
            wr_data  = (acc == 0) ? first : 8'($urandom);
            tick();
            acc++;
         end
      end
      wr_valid = 1'b0;
   endtask

   task automatic test_gaps_restart();
      int         p0;
      logic [7:0] first;
      logic [7:0] exp;
      wr_start = 1'b1; tick(); wr_start = 1'b0;
      p0 = done_pulses;
      send_beats(100, 8'($urandom));
      wr_start = 1'b1; wr_valid = 1'b1; wr_data = 8'h33;
      #1;
      n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL restart_wr_ready got %0b want 0", wr_ready); end
      tick();
      wr_start = 1'b0;
      first = 8'($urandom_range(0, 254));
      send_beats(1023, first);
      n_tests++; if (done_pulses !== p0) begin n_fail++; $display("FAIL restart_early_done got %0d pulses want %0d", done_pulses, p0); end
      wr_valid = 1'b1; wr_data = 8'($urandom); tick(); wr_valid = 1'b0;
      n_tests++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL restart_frame_done got %0b want 1", frame_done); end
      n_tests++; if (done_pulses !== p0 + 1) begin n_fail++; $display("FAIL restart_pulses got %0d want %0d", done_pulses, p0 + 1); end
      offsetX = 11'd0; offsetY = 11'd0; InsideRectangle = 1'b1;
      tick();
      n_tests++; if (RGBout !== first) begin n_fail++; $display("FAIL restart_origin got %h want %h", RGBout, first); end
      for (int k = 0; k < 8; k++) begin
         offsetX = 11'($urandom_range(0, 31)); offsetY = 11'($urandom_range(0, 31));
         exp = m_mem[int'(offsetY) * 32 + int'(offsetX)];
         tick();
         n_tests++; if (RGBout !== exp) begin n_fail++; $display("FAIL random_read x=%0d y=%0d got %h want %h", offsetX, offsetY, RGBout, exp); end
      end
   endtask

   task automatic test_outside();
      offsetX = 11'd40; offsetY = 11'd3; InsideRectangle = 1'b1;
      tick();
      n_tests++; if (RGBout !== 8'hFF) begin n_fail++; $display("FAIL oob_x40 got %h want ff", RGBout); end
      n_tests++; if (drawingRequest !== 1'b0) begin n_fail++; $display("FAIL oob_drawreq got %0b want 0", drawingRequest); end
      offsetX = 11'd3; offsetY = 11'd1500;
      tick();
      n_tests++; if (RGBout !== 8'hFF) begin n_fail++; $display("FAIL oob_y got %h want ff", RGBout); end
      InsideRectangle = 1'b0;
      for (int k = 0; k < 4; k++) begin
         offsetX = 11'($urandom_range(0, 31)); offsetY = 11'($urandom_range(0, 31));
         tick();
         n_tests++; if (RGBout !== 8'hFF) begin n_fail++; $display("FAIL outside_rect got %h want ff", RGBout); end
      end
   endtask

   task automatic test_collision();
      logic [7:0] old;
      wr_start = 1'b1; tick(); wr_start = 1'b0;
      old = m_mem[0];
      offsetX = 11'd0; offsetY = 11'd0; InsideRectangle = 1'b1;
      wr_valid = 1'b1; wr_data = 8'h1C;
      tick();
      n_tests++; if (RGBout !== old) begin n_fail++; $display("FAIL collision_old got %h want %h", RGBout, old); end
      wr_valid = 1'b0;
      tick();
      n_tests++; if (RGBout !== 8'h1C) begin n_fail++; $display("FAIL collision_new got %h want 1c", RGBout); end
   endtask

   task automatic test_reset_mid_load();
      logic [7:0] exp;
      wr_start = 1'b1; tick(); wr_start = 1'b0;
      wr_valid = 1'b1;
      for (int i = 0; i < 500; i++) begin
         wr_data = 8'($urandom);
         tick();
      end
      reset = 1'b1;
      tick();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %0b want 0", busy); end
      n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_wr_ready got %0b want 0", wr_ready); end
      reset = 1'b0; wr_valid = 1'b0;
      offsetX = 11'd0; offsetY = 11'd10; InsideRectangle = 1'b1;
      exp = m_mem[320];
      tick();
      n_tests++; if (RGBout !== exp) begin n_fail++; $display("FAIL midreset_keep got %h want %h", RGBout, exp); end
   endtask

`ifdef SPRITE_FRAME_WRITER_CLEAR_EN
   task automatic test_clear();
      int cnt, p0, bad;
      clear_req = 1'b1; wr_start = 1'b1;
      tick();
      clear_req = 1'b0; wr_start = 1'b0;
      p0  = done_pulses;
      cnt = (busy === 1'b1) ? 1 : 0;
      for (int k = 0; k < 1100 && busy === 1'b1; k++) begin
         tick();
         if (busy === 1'b1) cnt++;
      end
      n_tests++; if (cnt !== 1024) begin n_fail++; $display("FAIL clear_busy_cycles got %0d want 1024", cnt); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_timeout busy got %0b want 0", busy); end
      n_tests++; if (done_pulses !== p0) begin n_fail++; $display("FAIL clear_frame_done got %0d pulses want %0d", done_pulses, p0); end
      bad = 0; InsideRectangle = 1'b1;
      for (int a = 0; a < 1024; a++) begin
         offsetX = 11'(a % 32); offsetY = 11'(a / 32);
         tick();
         if (RGBout !== 8'hFF) bad++;
      end
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL clear_contents got %0d non-ff want 0", bad); end
   endtask
`endif

   task automatic test_model_consistency();
      n_tests++; if (err_ready !== 0) begin n_fail++; $display("FAIL model_wr_ready got %0d errors want 0", err_ready); end
      n_tests++; if (err_busy !== 0) begin n_fail++; $display("FAIL model_busy got %0d errors want 0", err_busy); end
      n_tests++; if (err_done !== 0) begin n_fail++; $display("FAIL model_frame_done got %0d errors want 0", err_done); end
      n_tests++; if (err_rd !== 0) begin n_fail++; $display("FAIL model_rgbout got %0d errors want 0", err_rd); end
      n_tests++; if (err_dr !== 0) begin n_fail++; $display("FAIL model_drawreq got %0d errors want 0", err_dr); end
   endtask

   initial begin
      reset = 1'b1; wr_start = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
      offsetX = 11'd0; offsetY = 11'd0; InsideRectangle = 1'b0;
`ifdef SPRITE_FRAME_WRITER_CLEAR_EN
      clear_req = 1'b0;
`endif
      m_load = 1'b0; m_clr = 1'b0; m_done = 1'b0; m_idx = 0; m_clr_cnt = 0;
      err_ready = 0; err_busy = 0; err_done = 0; err_rd = 0; err_dr = 0; done_pulses = 0;
      for (int a = 0; a < 1024; a++) begin
         m_mem[a] = 8'h00; m_known[a] = 1'b0;
      end
      test_reset();
      test_load();
      test_gaps_restart();
      test_outside();
      test_collision();
      test_reset_mid_load();
`ifdef SPRITE_FRAME_WRITER_CLEAR_EN
      test_clear();
`endif
      test_model_consistency();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
